// File: rtl/bch_pkg.sv
// Shared types and constants for the streaming BCH/cyclic encoder.
package bch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [8:0]  BCH_15_7_POLY  = 9'h1D1;
  localparam logic [4:0]  BCH_15_11_POLY = 5'h13;
  localparam logic [10:0] BCH_31_21_POLY = 11'h769;

  // Bit counter must hold K-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/bch_parity_lfsr.sv
// Bit-serial parity LFSR computing m(x)*x^R mod g(x), one message bit per shift, MSB first.
module bch_parity_lfsr #(
  parameter int unsigned R        = 8,
  parameter logic [63:0] GEN_POLY = 64'h1D1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         shift_en,
  input  logic         bit_in,
  output logic [R-1:0] parity,
  output logic [R-1:0] parity_next_c
);

  logic fb;

  // Uniform form also covers R=1, where the update collapses to parity <= fb.
  always_comb begin
    fb               = bit_in ^ parity[R-1];
    parity_next_c    = '0;
    parity_next_c[0] = fb & GEN_POLY[0];
    for (int unsigned i = 1; i < R; i++) begin
      parity_next_c[i] = parity[i-1] ^ (fb & GEN_POLY[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      parity <= '0;
    end else if (clear) begin
      parity <= '0;
    end else if (shift_en) begin
      parity <= parity_next_c;
    end
  end

endmodule

// File: rtl/bch_enc_stream.sv
// Parametrised systematic cyclic encoder with valid/ready on both sides; output holds under backpressure.
module bch_enc_stream
  import bch_pkg::*;
#(
  parameter int unsigned N        = 15,
  parameter int unsigned K        = 7,
  parameter logic [63:0] GEN_POLY = 64'(BCH_15_7_POLY)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] in_msg,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_code,
  output logic         busy
);

  localparam int unsigned R  = N - K;
  localparam int unsigned CW = cnt_width(K);

  if (!(N > K && K >= 1 && N <= 64)) begin : g_bad_size
    $error("bch_enc_stream: need 64 >= N > K >= 1");
  end
  if (GEN_POLY[R] != 1'b1 || GEN_POLY[0] != 1'b1 || (GEN_POLY >> (R + 1)) != 64'd0) begin : g_bad_poly
    $error("bch_enc_stream: GEN_POLY must have degree exactly N-K and a nonzero constant term");
  end

  state_t          state;
  state_t          state_next;
  logic            accept_c;
  logic            shift_c;
  logic [CW-1:0]   count;
  logic [K-1:0]    msg_reg;
  logic [R-1:0]    parity;
  logic [R-1:0]    parity_next_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Handshake outputs are pure decodes of the state register.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    accept_c   = 1'b0;
    shift_c    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept_c   = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy    = 1'b1;
        shift_c = 1'b1;
        if (count == '0) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      msg_reg  <= '0;
      out_code <= '0;
    end else begin
      if (accept_c) begin
        msg_reg <= in_msg;
        count   <= CW'(K - 1);
      end
      if (shift_c) begin
        if (count == '0) begin
          out_code <= {msg_reg, parity_next_c};
        end else begin
          count <= count - CW'(1);
        end
      end
    end
  end

  bch_parity_lfsr #(
    .R        (R),
    .GEN_POLY (GEN_POLY)
  ) u_lfsr (
    .clk           (clk),
    .reset         (reset),
    .clear         (accept_c),
    .shift_en      (shift_c),
    .bit_in        (msg_reg[count]),
    .parity        (parity),
    .parity_next_c (parity_next_c)
  );

  // The LFSR is frozen in HOLD, so it must agree with the parity field being presented.
  hold_parity_a : assert property (@(posedge clk) disable iff (reset)
    (state == HOLD) |-> (out_code[R-1:0] == parity));

endmodule
